// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 Hz timing constants, derived sync windows and the shared
// 12-bit RGB palette used by the renderers.
package vga_timing_pkg;

  localparam int unsigned CNT_W = 10;

  typedef logic [CNT_W-1:0] coord_t;
  typedef logic [11:0]      rgb_t;

  // Default horizontal timing, in pixels
  localparam int unsigned DEF_H_DISPLAY = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;

  // Default vertical timing, in lines
  localparam int unsigned DEF_V_DISPLAY = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  localparam int unsigned DEF_H_TOTAL =
      DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned DEF_V_TOTAL =
      DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int unsigned DEF_HS_START = DEF_H_DISPLAY + DEF_H_FRONT;
  localparam int unsigned DEF_HS_END   = DEF_HS_START + DEF_H_SYNC - 1;
  localparam int unsigned DEF_VS_START = DEF_V_DISPLAY + DEF_V_FRONT;
  localparam int unsigned DEF_VS_END   = DEF_VS_START + DEF_V_SYNC - 1;

  // Shared renderer palette (4 bits per channel, R:G:B)
  localparam rgb_t RGB_BLACK  = 12'h000;
  localparam rgb_t RGB_WHITE  = 12'hFFF;
  localparam rgb_t RGB_RED    = 12'hF00;
  localparam rgb_t RGB_GREEN  = 12'h0F0;
  localparam rgb_t RGB_BLUE   = 12'h00F;
  localparam rgb_t RGB_ORANGE = 12'hF80;
  localparam rgb_t RGB_BROWN  = 12'h840;
  localparam rgb_t RGB_GREY   = 12'h888;

  // Inclusive window test on full-width coordinates
  function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Pixel interface between the sync generator (master) and the renderers
// (slave). With VGA_SYNC_FRAME_CNT_EN defined it also carries frame_cnt.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic   p_tick;
  coord_t pixel_x;
  coord_t pixel_y;
  logic   video_on;
  logic   hsync;
  logic   vsync;
  logic   frame_start;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [15:0] frame_cnt;

  modport master (
    output p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start, frame_cnt
  );
  modport slave (
    input p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start, frame_cnt
  );
`else
  modport master (
    output p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start
  );
  modport slave (
    input p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start
  );
`endif

endinterface

// File: rtl/vga_tick_gen.sv
// Pixel-rate divider: counts 0..CLK_DIV-1 and emits a registered one-clock
// tick in the clock after the count wraps. wrap is the combinational
// "advance now" strobe for logic that must move on the same edge the tick rises.
module vga_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick,
  output logic wrap
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] div_cnt_q, div_cnt_d;
  logic            tick_q;

  assign wrap = (div_cnt_q == CntMax);
  assign tick = tick_q;

  // Next divider count, wrapping at CLK_DIV-1
  always_comb begin
    div_cnt_d = wrap ? '0 : div_cnt_q + CntW'(1);
  end

  // Divider and tick registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tick_q    <= wrap;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel tick, x/y counters, hsync, vsync,
// video_on and frame_start, all registered and mutually aligned.
// Optional feature: define VGA_SYNC_FRAME_CNT_EN to add a 16-bit frame counter.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK
) (
  input logic           clk,
  input logic           reset,
  vga_sync_gen_if.master vga
);

  localparam int unsigned HTotal = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t HMax    = CNT_W'(HTotal - 1);
  localparam coord_t VMax    = CNT_W'(VTotal - 1);
  localparam coord_t HDisp   = CNT_W'(H_DISPLAY);
  localparam coord_t VDisp   = CNT_W'(V_DISPLAY);
  localparam coord_t HsStart = CNT_W'(H_DISPLAY + H_FRONT);
  localparam coord_t HsEnd   = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t VsStart = CNT_W'(V_DISPLAY + V_FRONT);
  localparam coord_t VsEnd   = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  // Elaboration-time sanity checks on the timing parameters
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("vga_sync_gen: CLK_DIV must be >= 2");
  end
  if (HTotal >= 1024 || VTotal >= 1024) begin : g_bad_total
    $error("vga_sync_gen: timing totals must be < 1024");
  end

  logic   p_tick;
  logic   adv;
  coord_t x_q, x_d;
  coord_t y_q, y_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   video_on_q, video_on_d;
  logic   frame_start_q, frame_start_d;

  vga_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (p_tick),
    .wrap  (adv)
  );

  // Next raster position; syncs and video_on decode from the next position so
  // they land in the same clock as the counters
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    frame_start_d = 1'b0;
    if (adv) begin
      if (x_q == HMax) begin
        x_d = '0;
        if (y_q == VMax) begin
          y_d           = '0;
          frame_start_d = 1'b1;
        end else begin
          y_d = y_q + CNT_W'(1);
        end
      end else begin
        x_d = x_q + CNT_W'(1);
      end
    end
    hsync_d    = ~in_window(x_d, HsStart, HsEnd);
    vsync_d    = ~in_window(y_d, VsStart, VsEnd);
    video_on_d = (x_d < HDisp) && (y_d < VDisp);
  end

  // Raster state registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Frame counter steps with frame_start and wraps naturally at 16 bits
  always_comb begin
    frame_cnt_d = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  // Frame counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign vga.frame_cnt = frame_cnt_q;
`endif

  assign vga.p_tick      = p_tick;
  assign vga.pixel_x     = x_q;
  assign vga.pixel_y     = y_q;
  assign vga.video_on    = video_on_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen using a reduced raster so whole frames
// fit in a short run. The reference derives every output from the number of
// clock edges since reset release.
module tb_vga_sync_gen;

  localparam int unsigned D  = 3;
  localparam int unsigned HD = 20;
  localparam int unsigned HF = 3;
  localparam int unsigned HS = 5;
  localparam int unsigned HB = 4;
  localparam int unsigned VD = 12;
  localparam int unsigned VF = 2;
  localparam int unsigned VS = 2;
  localparam int unsigned VB = 3;
  localparam int unsigned HT = HD + HF + HS + HB;
  localparam int unsigned VT = VD + VF + VS + VB;
  localparam int unsigned FRAME_TICKS = HT * VT;

  logic clk = 1'b0;
  logic reset = 1'b1;

  int n_assert = 0;
  int n_fail   = 0;
  int unsigned k = 0;  // clock edges since reset release

  vga_sync_gen_if vga_bus ();

  vga_sync_gen #(
    .CLK_DIV   (D),
    .H_DISPLAY (HD),
    .H_FRONT   (HF),
    .H_SYNC    (HS),
    .H_BACK    (HB),
    .V_DISPLAY (VD),
    .V_FRONT   (VF),
    .V_SYNC    (VS),
    .V_BACK    (VB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .vga   (vga_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (k=%0d)", tag, obs, exp, k);
    end
  endtask

  // Expected outputs from elapsed pixel periods
  task automatic check_all();
    int unsigned t, x, y;
    logic ptick, fs, hs, vs, von;
    t     = k / D;
    x     = t % HT;
    y     = (t / HT) % VT;
    ptick = (k != 0) && (k % D == 0);
    fs    = ptick && (x == 0) && (y == 0);
    hs    = !((x >= HD + HF) && (x <= HD + HF + HS - 1));
    vs    = !((y >= VD + VF) && (y <= VD + VF + VS - 1));
    von   = (x < HD) && (y < VD);
    chk("p_tick", vga_bus.p_tick, ptick);
    chk("pixel_x", vga_bus.pixel_x, x);
    chk("pixel_y", vga_bus.pixel_y, y);
    chk("hsync", vga_bus.hsync, hs);
    chk("vsync", vga_bus.vsync, vs);
    chk("video_on", vga_bus.video_on, von);
    chk("frame_start", vga_bus.frame_start, fs);
`ifdef VGA_SYNC_FRAME_CNT_EN
    chk("frame_cnt", vga_bus.frame_cnt, (t / FRAME_TICKS) & 32'hFFFF);
`endif
  endtask

  task automatic step(input logic rst);
    reset = rst;
    @(posedge clk);
    if (rst) k = 0;
    else k++;
    #1;
    check_all();
  endtask

  initial begin
    int unsigned hs_low, vs_low, fs_cnt, target, n;

    // Reset state
    repeat (3) step(1'b1);

    // One full frame from release, ending on the wrap to (0,0)
    hs_low = 0;
    vs_low = 0;
    fs_cnt = 0;
    for (int i = 0; i < FRAME_TICKS * D; i++) begin
      step(1'b0);
      if (vga_bus.p_tick === 1'b1) begin
        if (vga_bus.hsync === 1'b0) hs_low++;
        if (vga_bus.vsync === 1'b0) vs_low++;
      end
      if (vga_bus.frame_start === 1'b1) fs_cnt++;
    end
    chk("hsync_low_ticks", hs_low, HS * VT);
    chk("vsync_low_ticks", vs_low, VS * HT);
    chk("frame_start_count", fs_cnt, 1);
    chk("frame_end_x", vga_bus.pixel_x, 0);
    chk("frame_end_y", vga_bus.pixel_y, 0);

    // Park inside both sync pulses, then a one-clock reset
    target = (k / D / FRAME_TICKS + 1) * FRAME_TICKS + (VD + VF + 1) * HT + (HD + HF + 2);
    n = target * D - k;
    for (int i = 0; i < n; i++) step(1'b0);
    chk("mid_sync_hsync_low", vga_bus.hsync, 1'b0);
    chk("mid_sync_vsync_low", vga_bus.vsync, 1'b0);
    step(1'b1);
    chk("after_reset_x", vga_bus.pixel_x, 0);
    chk("after_reset_hsync", vga_bus.hsync, 1'b1);
    for (int i = 0; i < 2 * D; i++) step(1'b0);

    // Randomized run lengths with occasional resets of random duration
    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(1200, 1);
      for (int i = 0; i < n; i++) step(1'b0);
      if ($urandom_range(3, 0) == 0) begin
        n = $urandom_range(3, 1);
        for (int i = 0; i < n; i++) step(1'b1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
